// File: rtl/m_framebuffer_if.sv
// Frame buffer bus: screen-driver read port, pixel plot handshake and clear control.
interface m_framebuffer_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned X_W    = 7,
  parameter int unsigned Y_W    = 6
);
  logic [ADDR_W-1:0] pixelAddress;
  logic [7:0]        pixelData;
  logic              plot_valid;
  logic              plot_ready;
  logic [X_W-1:0]    plot_x;
  logic [Y_W-1:0]    plot_y;
  logic [1:0]        plot_op;
  logic              clr_req;
  logic [7:0]        clr_pattern;
  logic              busy;
  logic              clr_done;

  // Requesting side (screen driver + drawing logic)
  modport master (
    output pixelAddress, plot_valid, plot_x, plot_y, plot_op, clr_req, clr_pattern,
    input  pixelData, plot_ready, busy, clr_done
  );

  // Frame buffer side
  modport slave (
    input  pixelAddress, plot_valid, plot_x, plot_y, plot_op, clr_req, clr_pattern,
    output pixelData, plot_ready, busy, clr_done
  );
endinterface

// File: rtl/m_framebuffer.sv
// 128x64 monochrome frame buffer for the SSD1306 driver.
// Independent registered read port, read-modify-write pixel plotting, full-buffer fill engine.
// Optional macro FB_AUTO_CLEAR_EN: run a fill with 8'h00 right after reset release.
module m_framebuffer #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned HEIGHT = 64,
  parameter int unsigned ADDR_W = 10
) (
  input logic            clk,
  input logic            rst_btn,
  m_framebuffer_if.slave fb
);

  localparam int unsigned DEPTH = WIDTH * HEIGHT / 8;
  localparam int unsigned Y_W   = $clog2(HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef FB_AUTO_CLEAR_EN
  localparam logic AUTO_CLR_RST = 1'b1;
`else
  localparam logic AUTO_CLR_RST = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    WR    = 2'd2,
    CLEAR = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        bitIdx;
    logic [1:0]        op;
  } plotReq_t;

  logic [7:0] mem [DEPTH];

  state_t            state, stateNxt;
  plotReq_t          req, reqNxt;
  logic [ADDR_W-1:0] clrAddr, clrAddrNxt;
  logic [7:0]        clrPat, clrPatNxt;
  logic              clrPending, clrPendingNxt;
  logic              autoPending, autoPendingNxt;
  logic [7:0]        rmwByte;
  logic [7:0]        modByte;
  logic [7:0]        bitMask;
  logic [7:0]        pixelDataQ;
  logic              memWe;
  logic [ADDR_W-1:0] memWaddr;
  logic [7:0]        memWdata;
  logic              plotReady_c;
  logic              accept_c;
  logic              clrDone_c;

  // Plots only enter from IDLE when no fill is requested or owed; a fill always wins
  assign plotReady_c = rst_btn && (state == IDLE) && !fb.clr_req && !clrPending && !autoPending;
  assign accept_c    = fb.plot_valid && plotReady_c;

  assign fb.plot_ready = plotReady_c;
  assign fb.busy       = (state != IDLE);
  assign fb.clr_done   = clrDone_c;
  assign fb.pixelData  = pixelDataQ;

  // Apply the captured plot operation to the byte fetched in RD
  always_comb begin
    bitMask = 8'(1) << req.bitIdx;
    modByte = rmwByte;
    unique case (req.op)
      2'b01:   modByte = rmwByte | bitMask;
      2'b10:   modByte = rmwByte & ~bitMask;
      2'b11:   modByte = rmwByte ^ bitMask;
      default: modByte = rmwByte;
    endcase
  end

  // Next-state, datapath-register and write-port control
  always_comb begin
    stateNxt       = state;
    reqNxt         = req;
    clrAddrNxt     = clrAddr;
    clrPatNxt      = clrPat;
    clrPendingNxt  = clrPending | (fb.clr_req && (state != IDLE));
    autoPendingNxt = autoPending;
    memWe          = 1'b0;
    memWaddr       = req.addr;
    memWdata       = modByte;
    clrDone_c      = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept_c) begin
          reqNxt.addr   = ADDR_W'({fb.plot_y[Y_W-1:3], fb.plot_x});
          reqNxt.bitIdx = fb.plot_y[2:0];
          reqNxt.op     = fb.plot_op;
          stateNxt      = RD;
        end else if (fb.clr_req || clrPending || autoPending) begin
          stateNxt   = CLEAR;
          clrAddrNxt = '0;
          if (autoPending) begin
            // Power-up fill first; a user request seen now runs afterwards
            clrPatNxt      = 8'h00;
            autoPendingNxt = 1'b0;
            clrPendingNxt  = clrPending | fb.clr_req;
          end else begin
            clrPatNxt     = fb.clr_pattern;
            clrPendingNxt = 1'b0;
          end
        end
      end
      RD: begin
        stateNxt = WR;
      end
      WR: begin
        memWe    = 1'b1;
        stateNxt = IDLE;
      end
      CLEAR: begin
        memWe      = 1'b1;
        memWaddr   = clrAddr;
        memWdata   = clrPat;
        clrAddrNxt = clrAddr + ADDR_W'(1);
        if (clrAddr == LAST_ADDR) begin
          clrDone_c = 1'b1;
          stateNxt  = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state       <= IDLE;
      req         <= '0;
      clrAddr     <= '0;
      clrPat      <= '0;
      clrPending  <= 1'b0;
      autoPending <= AUTO_CLR_RST;
    end else begin
      state       <= stateNxt;
      req         <= reqNxt;
      clrAddr     <= clrAddrNxt;
      clrPat      <= clrPatNxt;
      clrPending  <= clrPendingNxt;
      autoPending <= autoPendingNxt;
    end
  end

  // Screen-driver read port, read-first against the write side
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      pixelDataQ <= '0;
    end else begin
      pixelDataQ <= mem[fb.pixelAddress];
    end
  end

  // Internal read of the plot target byte
  always_ff @(posedge clk) begin
    if (state == RD) begin
      rmwByte <= mem[req.addr];
    end
  end

  // Write port shared by the plot RMW and the fill engine; array is never reset
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memWaddr] <= memWdata;
    end
  end

endmodule

// File: tb/tb_m_framebuffer.sv
// Self-checking bench for m_framebuffer: shadow-memory scoreboard on the read port.
module tb_m_framebuffer;

  typedef struct {
    logic [7:0] exp;
    int         addr;
  } rdItem_t;

  logic clk = 1'b0;
  logic rst_btn = 1'b0;
  always #5 clk = ~clk;

  m_framebuffer_if fbIf ();

  m_framebuffer dut (
    .clk     (clk),
    .rst_btn (rst_btn),
    .fb      (fbIf)
  );

  int nChk = 0;
  int nPass = 0;
  logic [7:0] model [1024];
  rdItem_t sbQ [$];
  logic rdReq = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a read address and record what the byte must be
  task automatic issueRead(input int a);
    rdItem_t it;
    it.exp = model[a];
    it.addr = a;
    fbIf.pixelAddress = 10'(a);
    sbQ.push_back(it);
    rdReq = 1'b1;
  endtask

  // Scoreboard: pixelData is valid one edge after the address was driven
  always @(posedge clk) begin
    if (rdReq) begin
      rdItem_t it;
      rdReq = 1'b0;
      #1;
      if (sbQ.size() != 0) begin
        it = sbQ.pop_front();
        nChk++;
        if (fbIf.pixelData !== it.exp)
          $display("FAIL read[%0d]: got %h expected %h", it.addr, fbIf.pixelData, it.exp);
        else
          nPass++;
      end
    end
  end

  // Follow a running fill: 1024 busy cycles, single clr_done on the last
  task automatic runClear(input logic [7:0] pat, input string name);
    int cnt = 0;
    int doneCnt = 0;
    int doneIdx = -1;
    for (int k = 0; k < 1100; k++) begin
      if (!fbIf.busy) break;
      if (fbIf.clr_done === 1'b1) begin
        doneCnt++;
        doneIdx = cnt;
      end
      cnt++;
      tick();
    end
    nChk++;
    if (cnt != 1024) $display("FAIL %s busy_cycles: got %0d expected 1024", name, cnt);
    else nPass++;
    nChk++;
    if (doneCnt != 1 || doneIdx != 1023)
      $display("FAIL %s clr_done: got %0d pulses at %0d expected 1 at 1023", name, doneCnt, doneIdx);
    else nPass++;
    for (int i = 0; i < 1024; i++) model[i] = pat;
  endtask

  task automatic startClear(input logic [7:0] pat, input string name);
    fbIf.clr_req = 1'b1;
    fbIf.clr_pattern = pat;
    #1;
    nChk++;
    if (fbIf.plot_ready !== 1'b0) $display("FAIL %s ready_on_req: got %b expected 0", name, fbIf.plot_ready);
    else nPass++;
    tick();
    fbIf.clr_req = 1'b0;
  endtask

  // One plot from IDLE; returns in IDLE after the RMW write
  task automatic doPlot(input int x, input int y, input logic [1:0] op, input string name);
    int a;
    logic [7:0] m;
    fbIf.plot_x = 7'(x);
    fbIf.plot_y = 6'(y);
    fbIf.plot_op = op;
    fbIf.plot_valid = 1'b1;
    #1;
    nChk++;
    if (fbIf.plot_ready !== 1'b1) $display("FAIL %s ready: got %b expected 1", name, fbIf.plot_ready);
    else nPass++;
    tick();
    fbIf.plot_valid = 1'b0;
    nChk++;
    if (fbIf.busy !== 1'b1) $display("FAIL %s busy_rd: got %b expected 1", name, fbIf.busy);
    else nPass++;
    a = (y / 8) * 128 + x;
    m = 8'(1) << (y % 8);
    case (op)
      2'b01: model[a] = model[a] | m;
      2'b10: model[a] = model[a] & ~m;
      2'b11: model[a] = model[a] ^ m;
      default: ;
    endcase
    tick();
    tick();
    nChk++;
    if (fbIf.busy !== 1'b0) $display("FAIL %s busy_end: got %b expected 0", name, fbIf.busy);
    else nPass++;
  endtask

  task automatic test_reset();
    tick();
    tick();
    nChk++;
    if (fbIf.pixelData !== 8'h00) $display("FAIL rst pixelData: got %h expected 00", fbIf.pixelData);
    else nPass++;
    nChk++;
    if (fbIf.busy !== 1'b0 || fbIf.clr_done !== 1'b0)
      $display("FAIL rst busy/done: got %b/%b expected 0/0", fbIf.busy, fbIf.clr_done);
    else nPass++;
    nChk++;
    if (fbIf.plot_ready !== 1'b0) $display("FAIL rst ready: got %b expected 0", fbIf.plot_ready);
    else nPass++;
    rst_btn = 1'b1;
    #1;
`ifdef FB_AUTO_CLEAR_EN
    nChk++;
    if (fbIf.plot_ready !== 1'b0) $display("FAIL rel ready: got %b expected 0", fbIf.plot_ready);
    else nPass++;
    tick();
    runClear(8'h00, "autoclr");
`else
    nChk++;
    if (fbIf.plot_ready !== 1'b1) $display("FAIL rel ready: got %b expected 1", fbIf.plot_ready);
    else nPass++;
    tick();
`endif
  endtask

  task automatic test_clear_a5();
    startClear(8'hA5, "clrA5");
    runClear(8'hA5, "clrA5");
    issueRead(0);    tick();
    issueRead(511);  tick();
    issueRead(1023); tick();
    tick();
  endtask

  task automatic test_plot_set();
    startClear(8'h00, "clr00");
    runClear(8'h00, "clr00");
    doPlot(5, 10, 2'b01, "set5_10");
    issueRead(133); tick();
    issueRead(5);   tick();
    tick();
  endtask

  task automatic test_toggle_clear();
    doPlot(127, 63, 2'b11, "tog1");
    issueRead(1023); tick(); tick();
    doPlot(127, 63, 2'b11, "tog2");
    issueRead(1023); tick(); tick();
    doPlot(5, 10, 2'b10, "clr5_10");
    issueRead(133); tick(); tick();
  endtask

  task automatic test_op_none();
    doPlot(5, 11, 2'b01, "set5_11");
    doPlot(5, 10, 2'b00, "none5_10");
    issueRead(133); tick(); tick();
  endtask

  task automatic test_clr_wins();
    fbIf.plot_x = 7'd5;
    fbIf.plot_y = 6'd16;
    fbIf.plot_op = 2'b01;
    fbIf.plot_valid = 1'b1;
    startClear(8'h5A, "clrwins");
    runClear(8'h5A, "clrwins");
    nChk++;
    if (fbIf.plot_ready !== 1'b1) $display("FAIL clrwins ready_after: got %b expected 1", fbIf.plot_ready);
    else nPass++;
    tick();
    fbIf.plot_valid = 1'b0;
    nChk++;
    if (fbIf.busy !== 1'b1) $display("FAIL clrwins accepted: got %b expected 1", fbIf.busy);
    else nPass++;
    model[261] = 8'h5B;
    tick();
    tick();
    issueRead(261); tick();
    issueRead(262); tick();
    tick();
  endtask

  task automatic test_clr_during_rd();
    fbIf.plot_x = 7'd7;
    fbIf.plot_y = 6'd32;
    fbIf.plot_op = 2'b01;
    fbIf.plot_valid = 1'b1;
    tick();
    fbIf.plot_valid = 1'b0;
    fbIf.clr_req = 1'b1;
    fbIf.clr_pattern = 8'hC3;
    model[519] = model[519] | 8'h01;
    tick();
    fbIf.clr_req = 1'b0;
    nChk++;
    if (dut.clrPending !== 1'b1) $display("FAIL rdclr pending_wr: got %b expected 1", dut.clrPending);
    else nPass++;
    tick();
    nChk++;
    if (fbIf.busy !== 1'b0 || fbIf.plot_ready !== 1'b0 || dut.clrPending !== 1'b1)
      $display("FAIL rdclr idle: got busy=%b ready=%b pend=%b expected 0 0 1",
               fbIf.busy, fbIf.plot_ready, dut.clrPending);
    else nPass++;
    issueRead(519);
    tick();
    nChk++;
    if (fbIf.busy !== 1'b1) $display("FAIL rdclr clear_start: got %b expected 1", fbIf.busy);
    else nPass++;
    runClear(8'hC3, "rdclr");
    issueRead(519); tick(); tick();
  endtask

  // Held plot_valid: one accept every 3 cycles, each RMW sees the previous write
  task automatic test_back_to_back();
    int accAt [3];
    int idx = 0;
    logic acc;
    fbIf.plot_x = 7'd10;
    fbIf.plot_y = 6'd0;
    fbIf.plot_op = 2'b11;
    fbIf.plot_valid = 1'b1;
    #1;
    acc = fbIf.plot_ready;
    if (acc) accAt[0] = 0;
    for (int c = 1; c < 40 && idx < 3; c++) begin
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) fbIf.plot_y = 6'(idx);
        else fbIf.plot_valid = 1'b0;
      end
      #1;
      acc = fbIf.plot_valid && fbIf.plot_ready;
      if (acc) accAt[idx] = c;
    end
    nChk++;
    if (idx != 3 || accAt[1] - accAt[0] != 3 || accAt[2] - accAt[1] != 3)
      $display("FAIL b2b spacing: got n=%0d at %0d,%0d,%0d expected 3 at 0,3,6",
               idx, accAt[0], accAt[1], accAt[2]);
    else nPass++;
    model[10] = model[10] ^ 8'h07;
    tick();
    tick();
    issueRead(10);  tick();
    issueRead(9);   tick();
    issueRead(11);  tick();
    issueRead(138); tick();
    tick();
  endtask

  task automatic test_reset_mid_clear();
    startClear(8'hFF, "rstclr");
    repeat (300) tick();
    rst_btn = 1'b0;
    #1;
    nChk++;
    if (fbIf.busy !== 1'b0 || fbIf.plot_ready !== 1'b0 || fbIf.pixelData !== 8'h00)
      $display("FAIL rstclr in_reset: got busy=%b ready=%b data=%h expected 0 0 00",
               fbIf.busy, fbIf.plot_ready, fbIf.pixelData);
    else nPass++;
    for (int i = 0; i < 300; i++) model[i] = 8'hFF;
    tick();
    rst_btn = 1'b1;
    #1;
`ifdef FB_AUTO_CLEAR_EN
    tick();
    runClear(8'h00, "rstauto");
`else
    nChk++;
    if (fbIf.plot_ready !== 1'b1 || fbIf.busy !== 1'b0)
      $display("FAIL rstclr release: got ready=%b busy=%b expected 1 0", fbIf.plot_ready, fbIf.busy);
    else nPass++;
    tick();
`endif
    issueRead(0);    tick();
    issueRead(299);  tick();
    issueRead(300);  tick();
    issueRead(1023); tick();
    tick();
  endtask

  initial begin
    fbIf.pixelAddress = '0;
    fbIf.plot_valid = 1'b0;
    fbIf.plot_x = '0;
    fbIf.plot_y = '0;
    fbIf.plot_op = 2'b00;
    fbIf.clr_req = 1'b0;
    fbIf.clr_pattern = 8'h00;
    for (int i = 0; i < 1024; i++) model[i] = 8'h00;

    test_reset();
    test_clear_a5();
    test_plot_set();
    test_toggle_clear();
    test_op_none();
    test_clr_wins();
    test_clr_during_rd();
    test_back_to_back();
    test_reset_mid_clear();

    nChk++;
    if (sbQ.size() != 0) $display("FAIL scoreboard drain: got %0d left expected 0", sbQ.size());
    else nPass++;
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
